rv32i_alu: RTL and testbench
============================

# rv32i_alu

Integer execute unit for the RV32I core. It decodes the raw 32-bit instruction word and combines the two register-file operands into a single 32-bit result. The result is registered on the clock edge and drives the writeback path. It covers the OP (R-type) and OP-IMM (I-type) integer instruction classes and, optionally, LUI.

## Interface
- No parameters.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high; clears the result register.
- inst  input  32  full instruction word, RISC-V base encoding.
- rs1  input  32  first source operand value.
- rs2  input  32  second source operand value; ignored for I-type.
- rd  output  32  registered result value.

## Operation
- Decode fields:
  - opcode = inst[6:0]
  - funct3 = inst[14:12]
  - funct7 = inst[31:25]
  - I-immediate = sign-extended inst[31:20]
  - shamt = operand_b[4:0]
- Operand B selection:
  - opcode 0110011 (OP): operand_b = rs2.
  - opcode 0010011 (OP-IMM): operand_b = I-immediate.
- Functions selected by funct3:
  - 000: OP with funct7=0100000 gives SUB (rs1-b); OP with funct7=0000000 gives ADD. OP-IMM always gives ADDI, and inst[30] is ignored.
  - 001: SLL (rs1 << shamt).
  - 010: SLT (signed compare, result 1 or 0).
  - 011: SLTU (unsigned compare, result 1 or 0).
  - 100: XOR.
  - 101: funct7=0000000 gives SRL (logical shift); funct7=0100000 gives SRA (arithmetic shift).
  - 110: OR.
  - 111: AND.
- Arithmetic is modulo 2^32. Carry and overflow are discarded and not reported.
- OP-IMM shifts: inst[31:25] must be 0000000 (SLLI, SRLI) or 0100000 (SRAI).
- Result is 32'h0 for any of the following:
  - unsupported opcode;
  - OP with a funct7 outside the legal set for its funct3;
  - OP-IMM shift with an illegal inst[31:25].
- No exception output exists.

## Timing
- Combinational result computed from inst, rs1 and rs2 in the same cycle.
- rd is updated on every rising edge of clk: latency 1 cycle, throughput 1 per cycle, no handshake.
- rst asserted: rd = 32'h0 immediately, regardless of clk. It holds 0 while rst is high.
- First edge after rst deasserts captures the current inputs.
- Reset asserted mid-stream: the in-flight result is discarded.
- Inputs changing between edges have no effect on rd until the next edge.
- X/undriven inputs before the first valid edge are tolerated. rd reflects only sampled values.

## Configuration
- Macro ALU_LUI_EN.
- Defined: opcode 0110111 (LUI) gives rd = {inst[31:12], 12'h0}, and rs1/rs2 are ignored.
- Undefined: LUI is treated as an unsupported opcode and gives rd = 32'h0.

## Structure
- Package alu_pkg holds:
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI;
  - funct3 constants for the eight functions;
  - funct7 constants F7_BASE and F7_ALT;
  - an enum alu_op_t (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI, NONE).
- One sub-module, alu_decode: a purely combinational block mapping inst to alu_op_t plus operand_b.
- Top level holds the datapath case on alu_op_t and the result register.

## Test plan
- rst=1 at any time -> rd=32'h0 without waiting for a clock edge. Release rst, then hold inst=32'h00000033 (ADD), rs1=32'hCAFEBABE, rs2=32'hDEADBEEF -> rd=32'hA9AC79AD one edge later.
- inst=32'h40000033 (SUB), rs1=32'hCAFEBABE, rs2=32'hDEADBEEF -> rd=32'hEC50FBCF. Funct3 sweep with the same operands:
  - SLT -> 32'h1
  - SLTU -> 32'h1
  - XOR -> 32'h14530451
  - OR -> 32'hDEFFBEFF
  - AND -> 32'hCAACBAAE
- Shifts with rs1=32'h80000000, rs2=32'h4:
  - SRA (32'h40005033) -> 32'hF8000000
  - SRL (32'h00005033) -> 32'h08000000
  - SLL -> 32'h0
- inst=32'hFFF00013 (ADDI imm -1), rs1=32'h0, rs2=32'h12345678 -> rd=32'hFFFFFFFF, confirming rs2 is ignored.
- Illegal cases, each -> rd=32'h0:
  - inst=32'h20000033 (bad funct7);
  - inst=32'h0000006F (JAL);
  - with ALU_LUI_EN undefined, inst=32'h12345037.
- With ALU_LUI_EN defined, inst=32'h12345037 -> rd=32'h12345000. Assert rst between two back-to-back ADDs -> rd=0 immediately, and the next post-reset edge yields the fresh sum.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings and operation enum for the RV32I integer execute unit.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI, NONE
  } alu_op_t;

  // Functions whose funct3 alone selects the operation (no funct7 variant).
  function automatic alu_op_t f3_plain_op(input logic [2:0] funct3);
    unique case (funct3)
      F3_SLT:  return SLT;
      F3_SLTU: return SLTU;
      F3_XOR:  return XOR;
      F3_OR:   return OR;
      F3_AND:  return AND;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of an RV32I instruction into an ALU operation and operand B.
// Optional LUI support is enabled by defining ALU_LUI_EN.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] inst_i,
  input  logic [31:0] rs2_i,
  output alu_op_t     op_o,
  output logic [31:0] operand_b_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic        unused_rd_field;

  assign opcode          = inst_i[6:0];
  assign funct3          = inst_i[14:12];
  assign funct7          = inst_i[31:25];
  assign imm_i           = {{20{inst_i[31]}}, inst_i[31:20]};
  assign unused_rd_field = ^inst_i[11:7];

  always_comb begin
    op_o        = NONE;
    operand_b_o = 32'h0;
    case (opcode)
      OPC_OP: begin
        operand_b_o = rs2_i;
        case (funct3)
          F3_ADD: begin
            if (funct7 == F7_BASE)     op_o = ADD;
            else if (funct7 == F7_ALT) op_o = SUB;
          end
          F3_SR: begin
            if (funct7 == F7_BASE)     op_o = SRL;
            else if (funct7 == F7_ALT) op_o = SRA;
          end
          F3_SLL: begin
            if (funct7 == F7_BASE) op_o = SLL;
          end
          default: begin
            if (funct7 == F7_BASE) op_o = f3_plain_op(funct3);
          end
        endcase
      end
      OPC_OP_IMM: begin
        operand_b_o = imm_i;
        case (funct3)
          // inst[30] belongs to the immediate here, so ADDI never becomes SUB.
          F3_ADD: op_o = ADD;
          F3_SLL: begin
            if (funct7 == F7_BASE) op_o = SLL;
          end
          F3_SR: begin
            if (funct7 == F7_BASE)     op_o = SRL;
            else if (funct7 == F7_ALT) op_o = SRA;
          end
          default: op_o = f3_plain_op(funct3);
        endcase
      end
`ifdef ALU_LUI_EN
      OPC_LUI: begin
        op_o        = LUI;
        operand_b_o = {inst_i[31:12], 12'h0};
      end
`endif
      default: op_o = NONE;
    endcase
  end

endmodule

// File: rtl/rv32i_alu.sv
// RV32I integer execute unit: OP / OP-IMM datapath with a registered result.
// Optional LUI support is enabled by defining ALU_LUI_EN.
module rv32i_alu
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic [31:0] rd
);

  alu_op_t     op;
  logic [31:0] operand_b;
  logic [4:0]  shamt;
  logic [31:0] result_d;
  logic [31:0] rd_q;

  alu_decode u_decode (
    .inst_i      (inst),
    .rs2_i       (rs2),
    .op_o        (op),
    .operand_b_o (operand_b)
  );

  assign shamt = operand_b[4:0];

  always_comb begin
    result_d = 32'h0;
    case (op)
      ADD:  result_d = rs1 + operand_b;
      SUB:  result_d = rs1 - operand_b;
      SLL:  result_d = rs1 << shamt;
      SLT:  result_d = {31'h0, $signed(rs1) < $signed(operand_b)};
      SLTU: result_d = {31'h0, rs1 < operand_b};
      XOR:  result_d = rs1 ^ operand_b;
      SRL:  result_d = rs1 >> shamt;
      SRA:  result_d = $unsigned($signed(rs1) >>> shamt);
      OR:   result_d = rs1 | operand_b;
      AND:  result_d = rs1 & operand_b;
      // Decode already placed the upper immediate on operand B.
      LUI:  result_d = operand_b;
      default: result_d = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= 32'h0;
    else     rd_q <= result_d;
  end

  assign rd = rd_q;

endmodule

// File: tb/tb_rv32i_alu.sv
// Scoreboard-driven testbench for rv32i_alu; define ALU_LUI_EN to exercise LUI.
module tb_rv32i_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [31:0] rd;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rv32i_alu dut (
    .clk  (clk),
    .rst  (rst),
    .inst (inst),
    .rs1  (rs1),
    .rs2  (rs2),
    .rd   (rd)
  );

  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e);
    inst = i;
    rs1  = a;
    rs2  = b;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    logic [31:0] e;
    rst = 1'b1;
    #1;
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL reset_async: rd=%h want %h", rd, 32'h0);
    end
    @(posedge clk);
    #1;
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL reset_hold: rd=%h want %h", rd, 32'h0);
    end
    rst = 1'b0;
    drive(32'h00000033, 32'hCAFEBABE, 32'hDEADBEEF, 32'hA9AC79AD);
    @(posedge clk);
    #1;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL first_add: scoreboard empty, rd=%h", rd);
    end else begin
      e = exp_q.pop_front();
      if (rd !== e) begin
        bad++;
        $display("FAIL first_add: rd=%h want %h", rd, e);
      end
    end
  endtask

  task automatic test_arith;
    logic [31:0] insts[7] = '{32'h40000033, 32'h00002033, 32'h00003033, 32'h00004033,
                              32'h00006033, 32'h00007033, 32'h00000033};
    logic [31:0] exps[7]  = '{32'hEC50FBCF, 32'h00000001, 32'h00000001, 32'h14530451,
                              32'hDEFFBEFF, 32'hCAACBAAE, 32'hA9AC79AD};
    logic [31:0] e;
    for (int i = 0; i < 7; i++) begin
      drive(insts[i], 32'hCAFEBABE, 32'hDEADBEEF, exps[i]);
      @(posedge clk);
      #1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL arith[%0d]: scoreboard empty, rd=%h", i, rd);
      end else begin
        e = exp_q.pop_front();
        if (rd !== e) begin
          bad++;
          $display("FAIL arith[%0d] inst=%h: rd=%h want %h", i, insts[i], rd, e);
        end
      end
    end
    // Operands swapped: signed and unsigned compares now disagree.
    drive(32'h00002033, 32'h00000001, 32'h80000000, 32'h0);
    @(posedge clk);
    #1;
    total++;
    e = exp_q.pop_front();
    if (rd !== e) begin
      bad++;
      $display("FAIL slt_neg: rd=%h want %h", rd, e);
    end
    drive(32'h00003033, 32'h00000001, 32'h80000000, 32'h1);
    @(posedge clk);
    #1;
    total++;
    e = exp_q.pop_front();
    if (rd !== e) begin
      bad++;
      $display("FAIL sltu_big: rd=%h want %h", rd, e);
    end
  endtask

  task automatic test_shift;
    logic [31:0] insts[5] = '{32'h40005033, 32'h00005033, 32'h00001033,
                              32'h40405013, 32'h00401013};
    logic [31:0] exps[5]  = '{32'hF8000000, 32'h08000000, 32'h00000000,
                              32'hF8000000, 32'h00000000};
    logic [31:0] e;
    for (int i = 0; i < 5; i++) begin
      drive(insts[i], 32'h80000000, 32'h00000004, exps[i]);
      @(posedge clk);
      #1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL shift[%0d]: scoreboard empty, rd=%h", i, rd);
      end else begin
        e = exp_q.pop_front();
        if (rd !== e) begin
          bad++;
          $display("FAIL shift[%0d] inst=%h: rd=%h want %h", i, insts[i], rd, e);
        end
      end
    end
    drive(32'h00101013, 32'h00000003, 32'h0000001F, 32'h00000006);
    @(posedge clk);
    #1;
    total++;
    e = exp_q.pop_front();
    if (rd !== e) begin
      bad++;
      $display("FAIL slli_1: rd=%h want %h", rd, e);
    end
  endtask

  task automatic test_imm;
    logic [31:0] e;
    drive(32'hFFF00013, 32'h00000000, 32'h12345678, 32'hFFFFFFFF);
    @(posedge clk);
    #1;
    total++;
    e = exp_q.pop_front();
    if (rd !== e) begin
      bad++;
      $display("FAIL addi_m1: rd=%h want %h", rd, e);
    end
    // inst[30] set on ADDI is immediate data, not a SUB selector.
    drive(32'h40000013, 32'h00000001, 32'h12345678, 32'h00000401);
    @(posedge clk);
    #1;
    total++;
    e = exp_q.pop_front();
    if (rd !== e) begin
      bad++;
      $display("FAIL addi_bit30: rd=%h want %h", rd, e);
    end
  endtask

  task automatic test_illegal;
    logic [31:0] insts[5] = '{32'h20000033, 32'h0000006F, 32'h40001013,
                              32'h40002033, 32'h02005013};
    logic [31:0] e;
    for (int i = 0; i < 5; i++) begin
      drive(32'h00000033, 32'h11111111, 32'h22222222, 32'h33333333);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      drive(insts[i], 32'hCAFEBABE, 32'hDEADBEEF, 32'h0);
      @(posedge clk);
      #1;
      total++;
      e = exp_q.pop_front();
      if (rd !== e) begin
        bad++;
        $display("FAIL illegal[%0d] inst=%h: rd=%h want %h", i, insts[i], rd, e);
      end
    end
  endtask

  task automatic test_lui;
    logic [31:0] e;
`ifdef ALU_LUI_EN
    drive(32'h12345037, 32'hCAFEBABE, 32'hDEADBEEF, 32'h12345000);
`else
    drive(32'h12345037, 32'hCAFEBABE, 32'hDEADBEEF, 32'h00000000);
`endif
    @(posedge clk);
    #1;
    total++;
    e = exp_q.pop_front();
    if (rd !== e) begin
      bad++;
      $display("FAIL lui: rd=%h want %h", rd, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      if (i[0]) drive(32'h00004033, a, b, a ^ b);
      else      drive(32'h00000033, a, b, a + b);
      @(posedge clk);
      #1;
      total++;
      e = exp_q.pop_front();
      if (rd !== e) begin
        bad++;
        $display("FAIL b2b[%0d]: rd=%h want %h", i, rd, e);
      end
    end
  endtask

  task automatic test_reset_midstream;
    logic [31:0] e;
    drive(32'h00000033, 32'h00000010, 32'h00000020, 32'h00000030);
    @(posedge clk);
    #1;
    total++;
    e = exp_q.pop_front();
    if (rd !== e) begin
      bad++;
      $display("FAIL pre_rst_add: rd=%h want %h", rd, e);
    end
    drive(32'h00000033, 32'h00000100, 32'h00000200, 32'h00000300);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL mid_rst_async: rd=%h want %h", rd, 32'h0);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    total++;
    if (rd !== 32'h0) begin
      bad++;
      $display("FAIL mid_rst_hold: rd=%h want %h", rd, 32'h0);
    end
    drive(32'h00000033, 32'h00001000, 32'h00002000, 32'h00003000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    e = exp_q.pop_front();
    if (rd !== e) begin
      bad++;
      $display("FAIL post_rst_add: rd=%h want %h", rd, e);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_imm();
    test_illegal();
    test_lui();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
